// File: rtl/dp_ram_port_ctrl.sv
// Single-port front-end for a dual-port RAM: valid/ready requests in, in-order read
// responses out through a 2-entry FIFO, with an optional zero-fill after reset.
module dp_ram_port_ctrl #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 12,
  parameter int STRB_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int WE_WIDTH       = WIDTH / STRB_WIDTH,
  parameter int ADDR_WIDTH     = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [WIDTH-1:0]      REQ_WDATA,
  input  logic [WE_WIDTH-1:0]   REQ_WSTRB,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [WIDTH-1:0]      RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [WIDTH-1:0]      MEM_WDATA,
  output logic [WE_WIDTH-1:0]   MEM_WE,
  input  logic [WIDTH-1:0]      MEM_RDATA,
  output logic                  INIT_DONE,
  output logic                  ADDR_ERR
);
  typedef enum logic {CLEAR, RUN} state_t;
  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } rsp_t;

  state_t                state, state_nxt;
  rsp_t                  fifo [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            occ;
  logic                  pend, pend_err;
  logic [ADDR_WIDTH-1:0] clr_cnt, addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  init_done_q, addr_err_q;
  logic                  acc, in_range, pop, clr_last;
  logic [2:0]            slots_used;

  assign in_range  = 32'(REQ_ADDR) < DEPTH;
  assign clr_last  = clr_cnt == ADDR_WIDTH'(DEPTH - 1);
  assign RSP_VALID = occ != 2'd0;
  assign pop       = RSP_VALID && RSP_READY;
  // A read may only issue if its response has a FIFO slot by the time it lands.
  assign slots_used = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
  assign REQ_READY  = init_done_q && (state == RUN) && (REQ_WRITE || slots_used < 3'd2);
  assign acc        = REQ_VALID && REQ_READY;
  assign RSP_RDATA  = fifo[rd_ptr].data;
  assign RSP_ERR    = RSP_VALID && fifo[rd_ptr].err;
  assign INIT_DONE  = init_done_q;
  assign ADDR_ERR   = addr_err_q;

  always_comb begin
    state_nxt = state;
    MEM_ADDR  = addr_q;
    MEM_WDATA = wdata_q;
    MEM_WE    = '0;
    case (state)
      CLEAR: begin
        MEM_ADDR  = clr_cnt;
        MEM_WDATA = '0;
        MEM_WE    = '1;
        if (clr_last) state_nxt = RUN;
      end
      default: begin
        if (acc) begin
          MEM_ADDR  = REQ_ADDR;
          MEM_WDATA = REQ_WDATA;
          if (REQ_WRITE && in_range) MEM_WE = REQ_WSTRB;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
      pend        <= 1'b0;
      pend_err    <= 1'b0;
      occ         <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo[0]     <= '0;
      fifo[1]     <= '0;
    end else begin
      state       <= state_nxt;
      addr_q      <= MEM_ADDR;
      wdata_q     <= MEM_WDATA;
      init_done_q <= state_nxt == RUN;
      addr_err_q  <= acc && !in_range;
      pend        <= acc && !REQ_WRITE;
      pend_err    <= !in_range;
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
      // RAM data lands one cycle after the address; out-of-range reads return zero.
      if (pend) begin
        fifo[wr_ptr] <= '{err: pend_err, data: pend_err ? '0 : MEM_RDATA};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(pend) - 2'(pop);
    end
  end
endmodule

// File: doc/dp_ram_port_ctrl.md
Name: dp_ram_port_ctrl

Overview:
- Request front-end for one port of the dual-port RAM, e.g. port A.
- Accepts read/write requests on a valid/ready interface and drives the RAM port pins (address, write data, byte-lane write enables).
- Returns read data in order on a valid/ready response interface, using a 2-entry response FIFO.
- After reset, optionally clears the whole RAM to zero before accepting traffic.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of STRB_WIDTH.
- DEPTH, 12, number of RAM words; need not be a power of two.
- STRB_WIDTH, 8, bits covered by one write-enable lane. WE_WIDTH = WIDTH/STRB_WIDTH; ADDR_WIDTH = $clog2(DEPTH).
- CLEAR_ON_RESET, 1, 1 = zero-fill the RAM after reset; 0 = skip the clear.

Ports:
- CLK  in  1  single clock; also drives the RAM port clock.
- RST_N  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  ADDR_WIDTH  word address.
- REQ_WDATA  in  WIDTH  write data.
- REQ_WSTRB  in  WE_WIDTH  per-lane write enables.
- RSP_VALID  out  1  read response valid.
- RSP_READY  in  1  read response ready.
- RSP_RDATA  out  WIDTH  read data.
- RSP_ERR  out  1  response belongs to an out-of-range read.
- MEM_ADDR  out  ADDR_WIDTH  to RAM ADDR.
- MEM_WDATA  out  WIDTH  to RAM W_DATA.
- MEM_WE  out  WE_WIDTH  to RAM W_EN.
- MEM_RDATA  in  WIDTH  from RAM R_DATA; valid one cycle after the address is sampled.
- INIT_DONE  out  1  high once the clear is finished.
- ADDR_ERR  out  1  one-cycle pulse when an out-of-range request is accepted.

Behaviour:
- Reset (RST_N low at a CLK edge):
  - RSP_VALID, RSP_ERR, INIT_DONE, ADDR_ERR, MEM_WE = 0; MEM_ADDR, MEM_WDATA, RSP_RDATA = 0.
  - Response FIFO emptied, read-pending flag cleared.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Reset mid-operation drops all pending responses; no response is ever emitted for them.
- FSM CLEAR:
  - Cycle i, for i = 0..DEPTH-1: MEM_ADDR=i, MEM_WDATA=0, MEM_WE=all ones.
  - REQ_READY=0, INIT_DONE=0.
  - After writing address DEPTH-1, go to RUN; INIT_DONE=1 from the next cycle.
  - The clear takes exactly DEPTH cycles.
- FSM RUN:
  - INIT_DONE=1. A request is accepted in cycle T when REQ_VALID && REQ_READY.
  - MEM_* are combinational from the accepted request.
  - When no request is accepted, MEM_WE=0; MEM_ADDR and MEM_WDATA hold their last values.
  - Write: MEM_WE=REQ_WSTRB. REQ_WSTRB=0 is accepted as a no-op and produces no response.
  - Read: MEM_WE=0. The read-pending flag is set for T+1, MEM_RDATA is pushed into the FIFO at the end of T+1, and RSP_VALID=1 from T+2 (latency 2).
  - REQ_READY = INIT_DONE && (REQ_WRITE || occ + pend - pop < 2), where pop = RSP_VALID && RSP_READY.
    - The combinational RSP_READY -> REQ_READY path is intentional.
    - Back-to-back reads sustain 1 per cycle while RSP_READY=1.
  - Writes are never blocked by a full response FIFO.
  - Responses are strictly in request order.
  - REQ_* must be held stable while REQ_VALID=1 and REQ_READY=0.
  - RSP_VALID, RSP_RDATA and RSP_ERR stay stable while RSP_READY=0.
- Out-of-range address (REQ_ADDR >= DEPTH):
  - Accepted normally, but MEM_WE=0. ADDR_ERR=1 in the cycle after acceptance.
  - Read: response pushed with RSP_RDATA=0, RSP_ERR=1, same latency and ordering as a normal read.
  - Write: dropped silently, no response.
- A write in T followed by a read of the same address in T+1 returns the new data.
- In CLEAR, REQ_VALID is ignored, nothing is consumed, and ADDR_ERR stays 0.

Test Plan:
- Reset, then hold RST_N=1 with DEPTH=12 -> MEM_WE=4'hF for cycles 0..11 with MEM_ADDR 0..11, MEM_WDATA=0; INIT_DONE=1 at cycle 12; REQ_READY=0 until then.
- Write 0xDEADBEEF to addr 5 with WSTRB=4'hF, then WSTRB=4'b0010 with data 0x0000AA00, then read addr 5 -> RSP_RDATA=0xDEADAAEF, RSP_VALID exactly 2 cycles after the read acceptance.
- Reads of addr 0,1,2,3 on consecutive cycles with RSP_READY=1 -> REQ_READY stays 1; four responses on consecutive cycles in order 0,1,2,3.
- RSP_READY=0, issue 3 reads -> first two accepted, third stalls (REQ_READY=0); raise RSP_READY -> third accepted in the same cycle as the first pop; order preserved, no data lost.
- Read addr 13 -> ADDR_ERR pulse; response RSP_RDATA=0, RSP_ERR=1; MEM_WE=0 throughout. Write addr 12 -> ADDR_ERR pulse, no response, RAM unchanged.
- Assert RST_N=0 for 1 cycle while two responses are pending -> RSP_VALID=0 the next cycle; clear sequence restarts from addr 0; no stale response appears afterwards.
